mult_div_unit: RTL and testbench

//   Multicycle signed multiply/divide responder serving the control unit's mult/div requests.

---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed multiply (radix-2 Booth) / divide (restoring)
//               unit producing hi/lo with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_MULT   = 2'd1;
  localparam logic [1:0] c_DIV    = 2'd2;
  localparam logic [1:0] c_FINISH = 2'd3;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_count;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH:0]     r_opB;
  logic [WIDTH-1:0]   r_low;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_boothBit;
  logic               r_negQ;
  logic               r_negR;
  logic               r_divZero;

  logic               w_accept;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_boothSum;
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH+1:0]   w_divDiff;
  logic [WIDTH:0]     w_accNext;
  logic [WIDTH-1:0]   w_lowNext;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // The done cycle doubles as an idle cycle so back-to-back requests are accepted.
  assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_FINISH));
  assign w_absA   = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign w_absB   = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

  always_comb begin
    w_boothSum = r_acc;
    case ({r_low[0], r_boothBit})
      2'b01:   w_boothSum = r_acc + r_opB;
      2'b10:   w_boothSum = r_acc - r_opB;
      default: w_boothSum = r_acc;
    endcase

    w_divShift = {r_acc[WIDTH-1:0], r_low[WIDTH-1]};
    w_divDiff  = {1'b0, w_divShift} - {1'b0, r_opB};

    if (r_state == c_DIV) begin
      if (!w_divDiff[WIDTH+1]) begin
        w_accNext = w_divDiff[WIDTH:0];
        w_lowNext = {r_low[WIDTH-2:0], 1'b1};
      end else begin
        w_accNext = w_divShift;
        w_lowNext = {r_low[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Arithmetic right shift of the whole {acc, low, boothBit} chain.
      w_accNext = {w_boothSum[WIDTH], w_boothSum[WIDTH:1]};
      w_lowNext = {w_boothSum[0], r_low[WIDTH-1:1]};
    end

    w_quot = r_negQ ? (~w_lowNext + 1'b1) : w_lowNext;
    w_rem  = r_negR ? (~w_accNext[WIDTH-1:0] + 1'b1) : w_accNext[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_count    <= '0;
      r_acc      <= '0;
      r_opB      <= '0;
      r_low      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_boothBit <= 1'b0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_divZero  <= 1'b0;
    end else begin
      r_divZero <= 1'b0;
      case (r_state)
        c_MULT, c_DIV: begin
          r_acc      <= w_accNext;
          r_low      <= w_lowNext;
          r_boothBit <= r_low[0];
          r_count    <= r_count + c_CNT_W'(1);
          if (r_count == c_LAST) begin
            r_state <= c_FINISH;
            r_count <= '0;
            if (r_state == c_DIV) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end else begin
              r_hi <= w_accNext[WIDTH-1:0];
              r_lo <= w_lowNext;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
          if (w_accept) begin
            r_acc      <= '0;
            r_boothBit <= 1'b0;
            r_count    <= '0;
            if (!op_div) begin
              r_state <= c_MULT;
              r_opB   <= {a_in[WIDTH-1], a_in};
              r_low   <= b_in;
            end else if (b_in != '0) begin
              r_state <= c_DIV;
              r_opB   <= {1'b0, w_absB};
              r_low   <= w_absA;
              r_negQ  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              r_negR  <= a_in[WIDTH-1];
            end else begin
              r_divZero <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy     = (r_state == c_MULT) || (r_state == c_DIV);
  assign done     = (r_state == c_FINISH);
  assign div_zero = r_divZero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op_div;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result {hi, lo} from plain signed arithmetic.
  function automatic logic [63:0] refResult(input logic opd, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (!opd) return sa * sb;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural model: a request occupies W busy cycles, then one done cycle.
  int           mRemain;
  logic         mBusy, mDone, mDz, mAccept;
  logic [W-1:0] mHi, mLo;
  logic [63:0]  mPend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mRemain = 0; mBusy = 0; mDone = 0; mDz = 0; mHi = '0; mLo = '0;
    end else begin
      mAccept = start && (mRemain == 0);
      mDone = 0;
      mDz   = 0;
      if (mRemain > 0) begin
        mRemain--;
        if (mRemain == 0) begin
          {mHi, mLo} = mPend;
          mDone = 1;
        end
      end
      if (mAccept) begin
        if (op_div && b_in == '0) mDz = 1;
        else begin
          mRemain = W;
          mPend   = refResult(op_div, a_in, b_in);
        end
      end
      mBusy = (mRemain > 0);
    end
  end

  always @(negedge clk) begin
    check("cyc busy", 64'(busy), 64'(mBusy));
    check("cyc done", 64'(done), 64'(mDone));
    check("cyc div_zero", 64'(div_zero), 64'(mDz));
    check("cyc hi", 64'(hi), 64'(mHi));
    check("cyc lo", 64'(lo), 64'(mLo));
  end

  // Issue one request (caller sits just after a rising edge) and wait for done.
  task automatic runOp(input logic opd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                       input string name, input int glitchAt);
    int lat, busyCnt;
    check({name, " model"}, refResult(opd, a, b), {expHi, expLo});
    start = 1; op_div = opd; a_in = a; b_in = b;
    @(posedge clk); #2;
    start = 0; a_in = $urandom; b_in = $urandom;
    lat = 1; busyCnt = 0;
    while (!done && lat < 60) begin
      if (busy) busyCnt++;
      if (lat == glitchAt) begin
        start = 1; op_div = 1; b_in = '0;
      end else start = 0;
      @(posedge clk); #2;
      if (lat == glitchAt) check({name, " ignored start"}, 64'(div_zero), 64'(0));
      lat++;
    end
    start = 0;
    check({name, " latency"}, 64'(lat), 64'(W + 1));
    check({name, " busy cycles"}, 64'(busyCnt), 64'(W));
    check({name, " hi"}, 64'(hi), 64'(expHi));
    check({name, " lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    int doneSeen;
    reset = 1; start = 0; op_div = 0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset busy", 64'(busy), 64'(0));
    check("reset hi/lo", {hi, lo}, 64'(0));
    reset = 0;

    runOp(0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mul 7*-3", 0);
    runOp(0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mul min*min", 0);
    runOp(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mul -1*-1", 0);
    runOp(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2", 0);
    runOp(1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2", 0);
    runOp(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div min/-1", 0);
    runOp(1, 32'h0000_0451, 32'h20, 32'h0000_0011, 32'h0000_0022, "div 0x451/0x20", 0);

    // Divide by zero: flagged next cycle, results held
    start = 1; op_div = 1; a_in = 32'd5; b_in = '0;
    @(posedge clk); #2;
    start = 0;
    check("dz pulse", 64'(div_zero), 64'(1));
    check("dz busy", 64'(busy), 64'(0));
    check("dz done", 64'(done), 64'(0));
    check("dz hi/lo held", {hi, lo}, 64'h0000_0011_0000_0022);
    @(posedge clk); #2;
    check("dz pulse ends", 64'(div_zero), 64'(0));
    check("dz hi/lo still held", {hi, lo}, 64'h0000_0011_0000_0022);

    // Mid-operation start ignored, then back-to-back acceptance in the done cycle
    runOp(0, 32'd1000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFE_7960, "mul glitch", 5);
    runOp(1, 32'd100, 32'd7, 32'd2, 32'd14, "div back-to-back", 0);

    // Abort a divide at iteration 10 with an asynchronous reset
    start = 1; op_div = 1; a_in = 32'd12345; b_in = 32'd17;
    @(posedge clk); #2;
    start = 0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1;
    #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort hi/lo", {hi, lo}, 64'(0));
    @(posedge clk); #2;
    reset = 0;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (done) doneSeen++;
    end
    check("abort no done", 64'(doneSeen), 64'(0));
    runOp(1, 32'd12345, 32'd17, 32'd3, 32'd726, "div after abort", 0);

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
